// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared execute-stage command codes, shift types and multiply FSM states
package arm_pkg;

    localparam logic [3:0] EXE_MOV   = 4'b0001;
    localparam logic [3:0] EXE_ADD   = 4'b0010;
    localparam logic [3:0] EXE_ADC   = 4'b0011;
    localparam logic [3:0] EXE_SUB   = 4'b0100;
    localparam logic [3:0] EXE_SBC   = 4'b0101;
    localparam logic [3:0] EXE_AND   = 4'b0110;
    localparam logic [3:0] EXE_ORR   = 4'b0111;
    localparam logic [3:0] EXE_EOR   = 4'b1000;
    localparam logic [3:0] EXE_MVN   = 4'b1001;
    localparam logic [3:0] EXE_MUL   = 4'b1010;
    localparam logic [3:0] EXE_UMULL = 4'b1011;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HI   = 2'd2
    } mul_state_e;

endpackage

// File: rtl/val2_generator.sv
// rtl/val2_generator.sv - second ALU operand: rotated immediate, memory offset or shifted register
module val2_generator
    import arm_pkg::*;
(
    input  logic        imm_i,
    input  logic        mem_en_i,
    input  logic [11:0] shift_operand_i,
    input  logic [31:0] val_rm_i,
    output logic [31:0] val2_o
);

    logic [31:0] imm8;
    logic [4:0]  rot_amt;
    logic [4:0]  sh_amt;

    // Rotates are built from two shifts; a left shift by 32 yields 0, so amount 0 is a plain copy
    always_comb begin
        imm8    = {24'b0, shift_operand_i[7:0]};
        rot_amt = {shift_operand_i[11:8], 1'b0};
        sh_amt  = shift_operand_i[11:7];
        val2_o  = '0;
        if (imm_i) begin
            val2_o = (imm8 >> rot_amt) | (imm8 << (6'd32 - {1'b0, rot_amt}));
        end else if (mem_en_i) begin
            val2_o = {20'b0, shift_operand_i};
        end else begin
            case (shift_operand_i[6:5])
                SH_LSL:  val2_o = val_rm_i << sh_amt;
                SH_LSR:  val2_o = val_rm_i >> sh_amt;
                SH_ASR:  val2_o = $signed(val_rm_i) >>> sh_amt;
                default: val2_o = (val_rm_i >> sh_amt) | (val_rm_i << (6'd32 - {1'b0, sh_amt}));
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, flags, branch target and iterative multiplier
module exe_stage
    import arm_pkg::*;
#(
    parameter int MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [3:0]  exec_cmd,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        wb_en_in,
    input  logic        status_w_en_in,
    input  logic        branch_taken_in,
    input  logic        imm_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn,
    input  logic [31:0] val_rm,
    input  logic [11:0] shift_operand,
    input  logic [23:0] signed_immed_24,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  status_in,
    output logic [31:0] alu_result,
    output logic [31:0] st_val,
    output logic [3:0]  dest_out,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        wb_en,
    output logic [3:0]  status_out,
    output logic        status_w_en,
    output logic        branch_taken,
    output logic [31:0] br_addr,
    output logic        busy
);

    localparam int         NSTEPS    = 32 / MUL_STEP;
    localparam logic [5:0] LAST_STEP = 6'(NSTEPS - 1);

    logic [31:0] val2;
    logic [31:0] alu_res;
    logic [3:0]  alu_nzcv;
    logic [32:0] sum;
    logic        c_f;
    logic        v_f;
    logic [31:0] br_target;
    logic [63:0] acc_d;

    mul_state_e  state_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic        umull_q;
    logic [3:0]  dest_l_q;
    logic        sw_l_q;
    logic [1:0]  cv_l_q;

    val2_generator u_val2 (
        .imm_i           (imm_in),
        .mem_en_i        (mem_r_en_in | mem_w_en_in),
        .shift_operand_i (shift_operand),
        .val_rm_i        (val_rm),
        .val2_o          (val2)
    );

    // Single-cycle ALU; C and V pass through from status_in unless the op is arithmetic
    always_comb begin
        sum     = '0;
        alu_res = '0;
        c_f     = status_in[1];
        v_f     = status_in[0];
        case (exec_cmd)
            EXE_MOV: alu_res = val2;
            EXE_MVN: alu_res = ~val2;
            EXE_ADD, EXE_ADC: begin
                sum     = {1'b0, val_rn} + {1'b0, val2}
                        + {32'b0, (exec_cmd == EXE_ADC) & status_in[1]};
                alu_res = sum[31:0];
                c_f     = sum[32];
                v_f     = (val_rn[31] == val2[31]) && (alu_res[31] != val_rn[31]);
            end
            EXE_SUB, EXE_SBC: begin
                sum     = {1'b0, val_rn} - {1'b0, val2}
                        - {32'b0, (exec_cmd == EXE_SBC) & ~status_in[1]};
                alu_res = sum[31:0];
                c_f     = ~sum[32];
                v_f     = (val_rn[31] != val2[31]) && (alu_res[31] != val_rn[31]);
            end
            EXE_AND: alu_res = val_rn & val2;
            EXE_ORR: alu_res = val_rn | val2;
            EXE_EOR: alu_res = val_rn ^ val2;
            default: alu_res = '0;
        endcase
        alu_nzcv  = {alu_res[31], alu_res == 32'd0, c_f, v_f};
        br_target = pc_in + {{6{signed_immed_24[23]}}, signed_immed_24, 2'b00};
    end

    // One multiply iteration: add the shifted multiplicand for each of the MUL_STEP low multiplier bits
    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (mplier_q[k]) begin
                acc_d = acc_d + (mcand_q << k);
            end
        end
    end

    // Output register and multiply FSM; outputs default to a bubble every cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            umull_q      <= 1'b0;
            dest_l_q     <= '0;
            sw_l_q       <= 1'b0;
            cv_l_q       <= '0;
            alu_result   <= '0;
            st_val       <= '0;
            dest_out     <= '0;
            mem_r_en     <= 1'b0;
            mem_w_en     <= 1'b0;
            wb_en        <= 1'b0;
            status_out   <= '0;
            status_w_en  <= 1'b0;
            branch_taken <= 1'b0;
            br_addr      <= '0;
            busy         <= 1'b0;
        end else begin
            alu_result   <= '0;
            st_val       <= '0;
            dest_out     <= '0;
            mem_r_en     <= 1'b0;
            mem_w_en     <= 1'b0;
            wb_en        <= 1'b0;
            status_out   <= '0;
            status_w_en  <= 1'b0;
            branch_taken <= 1'b0;
            br_addr      <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (exec_cmd == EXE_MUL || exec_cmd == EXE_UMULL) begin
                            state_q  <= ST_RUN;
                            busy     <= 1'b1;
                            cnt_q    <= '0;
                            acc_q    <= '0;
                            mcand_q  <= {32'b0, val_rn};
                            mplier_q <= val_rm;
                            umull_q  <= (exec_cmd == EXE_UMULL);
                            dest_l_q <= dest_in;
                            sw_l_q   <= status_w_en_in;
                            cv_l_q   <= status_in[1:0];
                        end else begin
                            alu_result   <= alu_res;
                            st_val       <= val_rm;
                            dest_out     <= dest_in;
                            mem_r_en     <= mem_r_en_in;
                            mem_w_en     <= mem_w_en_in;
                            wb_en        <= wb_en_in;
                            status_out   <= alu_nzcv;
                            status_w_en  <= status_w_en_in;
                            branch_taken <= branch_taken_in;
                            br_addr      <= br_target;
                        end
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << MUL_STEP;
                    mplier_q <= mplier_q >> MUL_STEP;
                    cnt_q    <= cnt_q + 6'd1;
                    if (cnt_q == LAST_STEP) begin
                        alu_result <= acc_d[31:0];
                        dest_out   <= dest_l_q;
                        wb_en      <= 1'b1;
                        if (umull_q) begin
                            state_q <= ST_HI;
                        end else begin
                            status_out  <= {acc_d[31], acc_d[31:0] == 32'd0, cv_l_q};
                            status_w_en <= sw_l_q;
                            busy        <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                ST_HI: begin
                    alu_result  <= acc_q[63:32];
                    dest_out    <= dest_l_q + 4'd1;
                    wb_en       <= 1'b1;
                    status_out  <= {acc_q[63], acc_q == 64'd0, cv_l_q};
                    status_w_en <= sw_l_q;
                    busy        <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage against a behavioural model
module tb_exe_stage;

    localparam int STEP = 1;
    localparam int NST  = 32 / STEP;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [3:0]  exec_cmd;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in;
    logic [31:0] pc_in, val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_immed_24;
    logic [3:0]  dest_in, status_in;
    logic [31:0] alu_result, st_val, br_addr;
    logic [3:0]  dest_out, status_out;
    logic        mem_r_en, mem_w_en, wb_en, status_w_en, branch_taken, busy;
    logic [109:0] obs;

    int tests_run = 0;
    int tests_failed = 0;

    exe_stage #(.MUL_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .exec_cmd(exec_cmd),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
        .status_w_en_in(status_w_en_in), .branch_taken_in(branch_taken_in), .imm_in(imm_in),
        .pc_in(pc_in), .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand),
        .signed_immed_24(signed_immed_24), .dest_in(dest_in), .status_in(status_in),
        .alu_result(alu_result), .st_val(st_val), .dest_out(dest_out), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .wb_en(wb_en), .status_out(status_out), .status_w_en(status_w_en),
        .branch_taken(branch_taken), .br_addr(br_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {alu_result, st_val, dest_out, mem_r_en, mem_w_en, wb_en, status_out,
                  status_w_en, branch_taken, br_addr, busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in = 0; exec_cmd = 0; mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
        status_w_en_in = 0; branch_taken_in = 0; imm_in = 0; pc_in = 0; val_rn = 0;
        val_rm = 0; shift_operand = 0; signed_immed_24 = 0; dest_in = 0; status_in = 0;
    endtask

    function automatic logic [109:0] pack(logic [31:0] res, logic [31:0] st, logic [3:0] d,
                                          logic mr, logic mw, logic wb, logic [3:0] f,
                                          logic sw, logic bt, logic [31:0] ba, logic bsy);
        return {res, st, d, mr, mw, wb, f, sw, bt, ba, bsy};
    endfunction

    // Second operand from the architectural rules, one bit position at a time
    function automatic logic [31:0] m_val2();
        logic [31:0] v;
        int n;
        if (imm_in) begin
            v = {24'b0, shift_operand[7:0]};
            n = 2 * int'(shift_operand[11:8]);
            for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
            return v;
        end
        if (mem_r_en_in || mem_w_en_in) return {20'b0, shift_operand};
        v = val_rm;
        n = int'(shift_operand[11:7]);
        for (int i = 0; i < n; i++) begin
            case (shift_operand[6:5])
                2'b00:   v = {v[30:0], 1'b0};
                2'b01:   v = {1'b0, v[31:1]};
                2'b10:   v = {v[31], v[31:1]};
                default: v = {v[0], v[31:1]};
            endcase
        end
        return v;
    endfunction

    // Expected registered bundle for a single-cycle instruction on the current inputs
    function automatic logic [109:0] exp_single();
        logic [31:0] b, res, br;
        logic c, v;
        longint unsigned us;
        longint ss, sd;
        int off;
        if (!valid_in) return '0;
        b = m_val2();
        res = 0; c = status_in[1]; v = status_in[0];
        case (exec_cmd)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd2, 4'd3: begin
                us = longint'(val_rn) + longint'(b) + ((exec_cmd == 4'd3 && status_in[1]) ? 1 : 0);
                ss = longint'($signed(val_rn)) + longint'($signed(b))
                   + ((exec_cmd == 4'd3 && status_in[1]) ? 1 : 0);
                res = us[31:0];
                c = (us > 64'hFFFF_FFFF);
                v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                sd = longint'(val_rn) - longint'(b) - ((exec_cmd == 4'd5 && !status_in[1]) ? 1 : 0);
                ss = longint'($signed(val_rn)) - longint'($signed(b))
                   - ((exec_cmd == 4'd5 && !status_in[1]) ? 1 : 0);
                res = sd[31:0];
                c = (sd >= 0);
                v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd6: res = val_rn & b;
            4'd7: res = val_rn | b;
            4'd8: res = val_rn ^ b;
            default: res = 0;
        endcase
        off = $signed(signed_immed_24);
        off = off * 4;
        br = pc_in + 32'(off);
        return pack(res, val_rm, dest_in, mem_r_en_in, mem_w_en_in, wb_en_in,
                    {res[31], res == 0, c, v}, status_w_en_in, branch_taken_in, br, 1'b0);
    endfunction

    // Accepts the multiply already on the inputs, then holds a random ADD upstream and collects writebacks
    task automatic mul_run(output int busy_cycles, output int wb_cnt, output int stray,
                           output logic [109:0] ev0, output logic [109:0] ev1);
        int guard;
        busy_cycles = 0; wb_cnt = 0; stray = 0; ev0 = '0; ev1 = '0; guard = 0;
        step();
        valid_in = 1; exec_cmd = 4'd2; imm_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        val_rn = $urandom; val_rm = $urandom; dest_in = 4'($urandom); status_in = 4'($urandom);
        shift_operand = 12'($urandom); wb_en_in = 1; status_w_en_in = 1'($urandom);
        branch_taken_in = 0; pc_in = $urandom; signed_immed_24 = 24'($urandom);
        while (busy === 1'b1 && guard < 200) begin
            busy_cycles++;
            if (wb_en === 1'b1) begin
                if (wb_cnt == 0) ev0 = obs; else ev1 = obs;
                wb_cnt++;
            end else if (obs !== 110'd1) begin
                stray++;
            end
            step();
            guard++;
        end
        if (wb_en === 1'b1) begin
            if (wb_cnt == 0) ev0 = obs; else ev1 = obs;
            wb_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 0;
        valid_in = 1; exec_cmd = 4'd2; val_rn = $urandom; val_rm = $urandom; wb_en_in = 1;
        branch_taken_in = 1; status_w_en_in = 1; dest_in = 4'd7;
        step(); step();
        tests_run++;
        if (obs !== 110'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected 0", obs);
        end
        rst = 1;
        clear_inputs();
    endtask

    task automatic test_directed();
        logic [109:0] e;
        clear_inputs();
        valid_in = 1; exec_cmd = 4'd2; imm_in = 1; shift_operand = 12'h2FF; val_rn = 5;
        status_w_en_in = 1; wb_en_in = 1; dest_in = 4'd3;
        e = exp_single(); step();
        tests_run++;
        if (alu_result !== 32'hF000_0014 || status_out !== 4'b1000) begin
            tests_failed++;
            $display("FAIL add_imm_rot: got %h/%b expected F0000014/1000", alu_result, status_out);
        end
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL add_imm_bundle: got %h expected %h", obs, e);
        end
        imm_in = 0; exec_cmd = 4'd4; val_rn = 32'h8000_0000; val_rm = 1; shift_operand = 0;
        step();
        tests_run++;
        if (alu_result !== 32'h7FFF_FFFF || status_out !== 4'b0011 || status_w_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_overflow: got %h/%b expected 7FFFFFFF/0011", alu_result, status_out);
        end
        exec_cmd = 4'd1; val_rm = 32'h0F00_0001; shift_operand = 12'h200;
        step();
        tests_run++;
        if (alu_result !== 32'hF000_0010) begin
            tests_failed++;
            $display("FAIL mov_lsl4: got %h expected F0000010", alu_result);
        end
        shift_operand = 12'h260;
        step();
        tests_run++;
        if (alu_result !== 32'h10F0_0000) begin
            tests_failed++;
            $display("FAIL mov_ror4: got %h expected 10F00000", alu_result);
        end
        clear_inputs();
        valid_in = 1; branch_taken_in = 1; pc_in = 32'h100; signed_immed_24 = 24'hFFFFFE;
        step();
        tests_run++;
        if (branch_taken !== 1'b1 || br_addr !== 32'h0000_00F8) begin
            tests_failed++;
            $display("FAIL branch: got %b/%h expected 1/000000F8", branch_taken, br_addr);
        end
        clear_inputs();
    endtask

    task automatic test_alu_random();
        logic [109:0] e;
        int bad;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            valid_in = ($urandom % 8) != 0;
            exec_cmd = 4'($urandom);
            if (exec_cmd == 4'd10 || exec_cmd == 4'd11) exec_cmd = 4'd3;
            imm_in = ($urandom % 3) == 0;
            mem_r_en_in = ($urandom % 5) == 0;
            mem_w_en_in = ($urandom % 5) == 0;
            wb_en_in = 1'($urandom); status_w_en_in = 1'($urandom);
            branch_taken_in = ($urandom % 6) == 0;
            pc_in = $urandom; val_rn = $urandom; val_rm = $urandom;
            if (i % 10 == 0) val_rm = 32'h8000_0000 | $urandom_range(0, 3);
            shift_operand = 12'($urandom); if (i % 7 == 0) shift_operand[11:7] = 5'd0;
            signed_immed_24 = 24'($urandom); dest_in = 4'($urandom); status_in = 4'($urandom);
            e = exp_single();
            step();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                bad++;
                if (bad < 6)
                    $display("FAIL alu_random[%0d] cmd=%h: got %h expected %h", i, exec_cmd, obs, e);
            end
        end
        clear_inputs();
    endtask

    task automatic test_multiply(input logic is_u, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] d, input logic sw, input logic [3:0] st);
        longint unsigned p;
        logic [109:0] ev0, ev1, e0, e1, e;
        int bc, wc, stray;
        p = longint'(a) * longint'(b);
        clear_inputs();
        valid_in = 1; exec_cmd = is_u ? 4'd11 : 4'd10; val_rn = a; val_rm = b; dest_in = d;
        status_w_en_in = sw; status_in = st; wb_en_in = 1;
        mul_run(bc, wc, stray, ev0, ev1);
        if (is_u) begin
            e0 = pack(p[31:0], 0, d, 0, 0, 1, 4'b0, 0, 0, 0, 1);
            e1 = pack(p[63:32], 0, d + 4'd1, 0, 0, 1, {p[63], p == 0, st[1:0]}, sw, 0, 0, 0);
        end else begin
            e0 = pack(p[31:0], 0, d, 0, 0, 1, {p[31], p[31:0] == 0, st[1:0]}, sw, 0, 0, 0);
            e1 = '0;
        end
        tests_run++;
        if (bc !== (is_u ? NST + 1 : NST) || wc !== (is_u ? 2 : 1) || stray !== 0) begin
            tests_failed++;
            $display("FAIL mul_timing u=%0d: busy=%0d wb=%0d stray=%0d expected busy=%0d wb=%0d stray=0",
                     is_u, bc, wc, stray, is_u ? NST + 1 : NST, is_u ? 2 : 1);
        end
        tests_run++;
        if (ev0 !== e0 || ev1 !== e1) begin
            tests_failed++;
            $display("FAIL mul_result u=%0d a=%h b=%h: got %h,%h expected %h,%h", is_u, a, b, ev0, ev1, e0, e1);
        end
        e = exp_single();
        step();
        tests_run++;
        if (obs !== e) begin
            tests_failed++;
            $display("FAIL held_after_mul: got %h expected %h", obs, e);
        end
        clear_inputs();
    endtask

    task automatic test_umull_plan();
        test_multiply(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 1'b1, 4'b0000);
        test_multiply(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd15, 1'b1, 4'b0011);
        test_multiply(1'b0, 32'h0001_0000, 32'h0001_0000, 4'd2, 1'b1, 4'b0010);
        for (int i = 0; i < 4; i++)
            test_multiply(1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom), 4'($urandom));
    endtask

    task automatic test_reset_mid_mul();
        logic [109:0] e;
        clear_inputs();
        valid_in = 1; exec_cmd = 4'd10; val_rn = $urandom; val_rm = $urandom; dest_in = 4'd6;
        wb_en_in = 1; status_w_en_in = 1;
        step();
        for (int i = 0; i < 10; i++) step();
        rst = 0;
        step();
        tests_run++;
        if (obs !== 110'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_mul: got %h expected 0", obs);
        end
        rst = 1;
        clear_inputs();
        valid_in = 1; exec_cmd = 4'd2; val_rn = 32'd100; val_rm = 32'd23; wb_en_in = 1; dest_in = 4'd1;
        e = exp_single();
        step();
        tests_run++;
        if (obs !== e || alu_result !== 32'd123) begin
            tests_failed++;
            $display("FAIL add_after_reset: got %h expected %h", obs, e);
        end
        for (int i = 0; i < 40; i++) begin
            step();
        end
        tests_run++;
        if (wb_en !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_stale_mul: wb_en=%b busy=%b expected 1/0", wb_en, busy);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        test_reset();
        test_directed();
        test_alu_random();
        test_umull_plan();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
